fifo_unpacker: RTL and testbench

Read-side consumer for the team's show-ahead `fifo`. It pops DATA_WIDTH-bit words using the FIFO's `n_empty`/`data_out`/`r_en` interface. Each word is re-emitted as RATIO = DATA_WIDTH/OUT_WIDTH narrower beats on a valid/ready stream. It sits between a `fifo` instance and a narrow downstream link, and sustains one beat per cycle, including across word boundaries.

---
 rtl/fifo_unpacker.sv | 88 ++++++++
 tb/tb_fifo_unpacker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_unpacker.sv
// rtl/fifo_unpacker.sv - show-ahead FIFO word to narrow valid/ready beat unpacker (optional FIFO_UNPACKER_MSB_FIRST_EN)
module fifo_unpacker #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fifo_n_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int RATIO  = DATA_WIDTH / OUT_WIDTH;
    localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic [BEAT_W-1:0]     beat_q;
    logic                  held;
    logic                  fire;
    logic                  done;
    logic [OUT_WIDTH-1:0]  slices [RATIO];

    // A word that does not split evenly into beats cannot be unpacked.
    generate
        if (DATA_WIDTH % OUT_WIDTH != 0) begin : g_width_check
            $error("fifo_unpacker: DATA_WIDTH must be a multiple of OUT_WIDTH");
        end
    endgenerate

    // Slice table in emission order: entry k is the beat sent at beat_q == k.
    for (genvar i = 0; i < RATIO; i++) begin : g_slice
`ifdef FIFO_UNPACKER_MSB_FIRST_EN
        assign slices[i] = word_q[(RATIO-1-i)*OUT_WIDTH +: OUT_WIDTH];
`else
        assign slices[i] = word_q[i*OUT_WIDTH +: OUT_WIDTH];
`endif
    end

    assign held      = (state_q == SEND);
    assign out_valid = held;
    assign out_last  = held & (beat_q == LAST_BEAT);
    assign fire      = out_valid & out_ready;
    assign done      = fire & out_last;
    // Pop on the cycle the last beat is taken so consecutive words have no bubble;
    // reset_n gates it so nothing is requested while the pair is held in reset.
    assign fifo_r_en = reset_n & ~flush & fifo_n_empty & (~held | done);

    // Beat select mux over the slice table.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (beat_q == BEAT_W'(k)) begin
                out_data = slices[k];
            end
        end
    end

    // Load on pop, release on last beat or flush, otherwise advance on each accepted beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            word_q  <= '0;
            beat_q  <= '0;
        end else if (fifo_r_en) begin
            state_q <= SEND;
            word_q  <= fifo_data;
            beat_q  <= '0;
        end else if (done || flush) begin
            state_q <= EMPTY;
            beat_q  <= '0;
        end else if (fire) begin
            beat_q  <= beat_q + BEAT_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_unpacker.sv
// tb/tb_fifo_unpacker.sv - directed self-checking bench for fifo_unpacker
module tb_fifo_unpacker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fifo_n_empty;
    logic [15:0] fifo_data;
    logic        fifo_r_en;
    logic        flush;
    logic        out_valid;
    logic [3:0]  out_data;
    logic        out_last;
    logic        out_ready;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [15:0] q[$];
    logic [3:0]  ex [4];
    logic [3:0]  ex2 [4];

    fifo_unpacker #(.DATA_WIDTH(16), .OUT_WIDTH(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fifo_n_empty (fifo_n_empty),
        .fifo_data    (fifo_data),
        .fifo_r_en    (fifo_r_en),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    // Emission position of the k-th nibble listed LSB-first.
    function automatic int ix(input int k);
`ifdef FIFO_UNPACKER_MSB_FIRST_EN
        return 3 - k;
`else
        return k;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic refresh();
        fifo_n_empty = (q.size() != 0);
        fifo_data    = (q.size() != 0) ? q[0] : 16'h0000;
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        q.push_back(w);
        refresh();
    endtask

    // One clock: the FIFO model pops if fifo_r_en was high before the edge.
    task automatic tick();
        logic re;
        re = fifo_r_en;
        checks++;
        assert (!(re && q.size() == 0)) else begin
            errors++;
            $error("FAIL pop_on_empty: observed 1 expected 0");
        end
        @(posedge clk);
        #1;
        if (re && reset_n) begin
            void'(q.pop_front());
            pops++;
        end
        refresh();
    endtask

    task automatic beat(input string tag, input logic [3:0] d, input logic last, input logic ren);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_last"},  32'(out_last),  32'(last));
        chk({tag, "_ren"},   32'(fifo_r_en), 32'(ren));
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        refresh();
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_ren",   32'(fifo_r_en), 32'd0);
        reset_n = 1'b1;
        #1;

        // Empty FIFO: nothing happens for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            chk("idle_valid", 32'(out_valid), 32'd0);
            chk("idle_ren",   32'(fifo_r_en), 32'd0);
            tick();
        end
        chk("idle_pops", 32'(pops), 32'd0);

        // Single word 0xA5C3.
        out_ready = 1'b1;
        push(16'hA5C3);
        chk("w1_ren", 32'(fifo_r_en), 32'd1);
        chk("w1_valid_pre", 32'(out_valid), 32'd0);
        tick();
        ex = '{4'h3, 4'hC, 4'h5, 4'hA};
        for (int k = 0; k < 4; k++) begin
            beat("w1", ex[ix(k)], k == 3, 1'b0);
            tick();
        end
        chk("w1_valid_post", 32'(out_valid), 32'd0);
        chk("w1_pops", 32'(pops), 32'd1);

        // Back-to-back words 0x1234, 0xBEEF with no bubble.
        push(16'h1234);
        push(16'hBEEF);
        chk("b2b_ren0", 32'(fifo_r_en), 32'd1);
        tick();
        ex  = '{4'h4, 4'h3, 4'h2, 4'h1};
        ex2 = '{4'hF, 4'hE, 4'hE, 4'hB};
        for (int k = 0; k < 4; k++) begin
            beat("b2b_a", ex[ix(k)], k == 3, k == 3);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            beat("b2b_b", ex2[ix(k)], k == 3, 1'b0);
            tick();
        end
        chk("b2b_valid_post", 32'(out_valid), 32'd0);
        chk("b2b_pops", 32'(pops), 32'd3);

        // Backpressure on 0x00F0.
        push(16'h00F0);
        tick();
        ex = '{4'h0, 4'hF, 4'h0, 4'h0};
        begin
            logic rdy [8];
            int   k;
            rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
            k = 0;
            for (int i = 0; i < 8; i++) begin
                out_ready = rdy[i];
                #1;
                beat("bp", ex[ix(k)], k == 3, 1'b0);
                tick();
                if (rdy[i]) k++;
            end
        end
        out_ready = 1'b1;
        #1;
        chk("bp_valid_post", 32'(out_valid), 32'd0);
        chk("bp_pops", 32'(pops), 32'd4);

        // Flush during beat 2 of 0x5678 with 0x9ABC queued.
        push(16'h5678);
        push(16'h9ABC);
        tick();
        ex  = '{4'h8, 4'h7, 4'h6, 4'h5};
        ex2 = '{4'hC, 4'hB, 4'hA, 4'h9};
        for (int k = 0; k < 2; k++) begin
            beat("fl_a", ex[ix(k)], 1'b0, 1'b0);
            tick();
        end
        flush = 1'b1;
        #1;
        beat("fl_cyc", ex[ix(2)], 1'b0, 1'b0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_empty_valid", 32'(out_valid), 32'd0);
        chk("fl_empty_ren",   32'(fifo_r_en), 32'd1);
        tick();
        for (int k = 0; k < 4; k++) begin
            beat("fl_b", ex2[ix(k)], k == 3, 1'b0);
            tick();
        end
        chk("fl_pops", 32'(pops), 32'd6);

        // Asynchronous reset mid-word.
        push(16'h1234);
        tick();
        tick();
        ex = '{4'h4, 4'h3, 4'h2, 4'h1};
        beat("ar_pre", ex[ix(1)], 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        q.delete();
        refresh();
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_data",  32'(out_data),  32'd0);
        chk("ar_last",  32'(out_last),  32'd0);
        chk("ar_ren",   32'(fifo_r_en), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("ar_rel_valid", 32'(out_valid), 32'd0);
        push(16'h4321);
        chk("ar_ren1", 32'(fifo_r_en), 32'd1);
        tick();
        ex = '{4'h1, 4'h2, 4'h3, 4'h4};
        for (int k = 0; k < 4; k++) begin
            beat("ar_post", ex[ix(k)], k == 3, 1'b0);
            tick();
        end
        chk("ar_valid_post", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
